// File: rtl/noc_output_scheduler_if.sv
// Bundle between the output-port scheduler, its five input VCs and the downstream link.
// master = scheduler side, slave = VC/link side.
interface noc_output_scheduler_if #(
    parameter int NUM_PORTS  = 5,
    parameter int DATA_WIDTH = 32,
    parameter int CW         = 3
);
    logic [NUM_PORTS-1:0]            vc_req;
    logic [NUM_PORTS*DATA_WIDTH-1:0] vc_data;
    logic [NUM_PORTS-1:0]            port_mask;
    logic [NUM_PORTS-1:0]            vc_pop;
    logic [DATA_WIDTH-1:0]           out_packet;
    logic                            out_valid;
    logic                            out_ready;
    logic                            credit_in;
    logic [CW-1:0]                   credits_avail;
    logic [2:0]                      last_grant;
    logic                            credit_err;

    modport master (
        input  vc_req, vc_data, port_mask, out_ready, credit_in,
        output vc_pop, out_packet, out_valid, credits_avail, last_grant, credit_err
    );
    modport slave (
        output vc_req, vc_data, port_mask, out_ready, credit_in,
        input  vc_pop, out_packet, out_valid, credits_avail, last_grant, credit_err
    );
endinterface

// File: rtl/noc_output_scheduler.sv
// Router output port: round-robin VC arbitration, credit-based flow control and
// a one-entry output register that holds each packet until downstream accepts it.
module noc_output_scheduler #(
    parameter int NUM_PORTS  = 5,
    parameter int DATA_WIDTH = 32,
    parameter int CREDITS    = 4,
    parameter int CW         = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    noc_output_scheduler_if.master bus
);
    localparam int            PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    logic [PW-1:0]         ptr_q, ptr_d, gnt_idx;
    logic [DATA_WIDTH-1:0] pkt_q, pkt_d, gnt_data;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic [CW-1:0]         cred_q, cred_d;
    logic [2:0]            last_q, last_d;
    logic [NUM_PORTS-1:0]  elig, gnt_oh;
    logic                  can_grant, found;

    // Grants use the registered credit count, so a returned credit is usable next cycle.
    always_comb begin : arb
        int j;
        elig      = bus.vc_req & bus.port_mask;
        can_grant = (|elig) && (!valid_q || bus.out_ready) && (cred_q != '0) && !rst;
        gnt_oh    = '0;
        gnt_idx   = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NUM_PORTS) j = j - NUM_PORTS;
            if (!found && elig[j]) begin
                found     = 1'b1;
                gnt_idx   = PW'(j);
                gnt_oh[j] = can_grant;
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (gnt_oh[i]) gnt_data = bus.vc_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        ptr_d   = ptr_q;
        pkt_d   = pkt_q;
        valid_d = valid_q;
        last_d  = last_q;
        cred_d  = cred_q;
        err_d   = err_q;
        if (can_grant) begin
            pkt_d   = gnt_data;
            valid_d = 1'b1;
            last_d  = 3'(gnt_idx);
            ptr_d   = (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + PW'(1);
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
        // A grant and a returned credit in the same cycle cancel out.
        case ({can_grant, bus.credit_in})
            2'b10:   cred_d = cred_q - CW'(1);
            2'b01: begin
                if (cred_q == CRED_MAX) err_d  = 1'b1;
                else                    cred_d = cred_q + CW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            pkt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= '0;
            cred_q  <= CRED_MAX;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            pkt_q   <= pkt_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            cred_q  <= cred_d;
            err_q   <= err_d;
        end
    end

    assign bus.vc_pop        = gnt_oh;
    assign bus.out_packet    = pkt_q;
    assign bus.out_valid     = valid_q;
    assign bus.credits_avail = cred_q;
    assign bus.last_grant    = last_q;
    assign bus.credit_err    = err_q;
endmodule

// File: tb/tb_noc_output_scheduler.sv
// Directed scenarios plus random traffic against a queue-free behavioural model of the port.
module tb_noc_output_scheduler;
    localparam int N = 5, DW = 32, CRED = 4, CW = 3;

    logic clk = 1'b0;
    logic rst;
    int   total = 0, bad = 0;

    noc_output_scheduler_if #(.NUM_PORTS(N), .DATA_WIDTH(DW), .CW(CW)) bus ();
    noc_output_scheduler #(.NUM_PORTS(N), .DATA_WIDTH(DW), .CREDITS(CRED), .CW(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [N-1:0] req, input logic rdy, input logic cin);
        bus.vc_req    = req;
        bus.out_ready = rdy;
        bus.credit_in = cin;
    endtask

    // Reference model: state sampled mid-cycle, next state committed at the edge.
    initial begin : model
        int        m_ptr, m_cred, m_last, n_ptr, n_cred, n_last, g, i;
        bit        m_valid, m_err, m_known, n_valid, n_err, n_known;
        logic [DW-1:0] m_pkt, n_pkt;
        logic [N-1:0]  elig, exp_pop;
        m_known = 0; m_ptr = 0; m_cred = 0; m_last = 0; m_valid = 0; m_err = 0; m_pkt = '0;
        forever begin
            @(negedge clk);
            elig = bus.vc_req & bus.port_mask;
            exp_pop = '0; g = -1;
            n_ptr = m_ptr; n_cred = m_cred; n_last = m_last; n_valid = m_valid;
            n_err = m_err; n_pkt = m_pkt; n_known = m_known;
            if (rst) begin
                n_ptr = 0; n_cred = CRED; n_last = 0; n_valid = 0; n_err = 0; n_pkt = '0;
                n_known = 1;
            end else if (m_known) begin
                if (elig != 0 && (!m_valid || bus.out_ready) && m_cred > 0)
                    for (int k = 0; k < N; k++) begin
                        i = (m_ptr + k) % N;
                        if (g < 0 && elig[i]) g = i;
                    end
                if (g >= 0) begin
                    exp_pop[g] = 1'b1;
                    n_pkt   = bus.vc_data[g*DW +: DW];
                    n_valid = 1;
                    n_last  = g;
                    n_ptr   = (g + 1) % N;
                end else if (bus.out_ready) n_valid = 0;
                n_cred = m_cred - ((g >= 0) ? 1 : 0) + (bus.credit_in ? 1 : 0);
                if (n_cred > CRED) begin
                    n_cred = CRED;
                    n_err  = 1;
                end
            end
            if (rst || m_known) chk("model_vc_pop", bus.vc_pop, exp_pop);
            if (m_known) begin
                chk("model_out_valid", bus.out_valid, m_valid);
                chk("model_out_packet", bus.out_packet, m_pkt);
                chk("model_credits", bus.credits_avail, m_cred);
                chk("model_last_grant", bus.last_grant, m_last);
                chk("model_credit_err", bus.credit_err, m_err);
            end
            @(posedge clk);
            m_ptr = n_ptr; m_cred = n_cred; m_last = n_last; m_valid = n_valid;
            m_err = n_err; m_pkt = n_pkt; m_known = n_known;
        end
    end

    initial begin : stim
        rst = 1'b1;
        bus.port_mask = 5'h1F;
        drv(5'h00, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) bus.vc_data[i*DW +: DW] = 32'hA000_0000 + i;
        cyc(); cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_credits", bus.credits_avail, 4);
        chk("rst_pop", bus.vc_pop, 0);
        chk("rst_err", bus.credit_err, 0);

        // round robin with a credit returned every cycle after the first grant
        cyc(); drv(5'h1F, 1'b1, 1'b0);
        @(negedge clk);
        chk("rr_pop_first", bus.vc_pop, 5'h01);
        for (int k = 1; k <= 5; k++) begin
            cyc(); bus.credit_in = 1'b1;
            @(negedge clk);
            chk("rr_pop", bus.vc_pop, 1 << (k % 5));
            chk("rr_last", bus.last_grant, (k - 1) % 5);
            chk("rr_credits", bus.credits_avail, 3);
            chk("rr_packet", bus.out_packet, 32'hA000_0000 + (k - 1) % 5);
        end
        cyc(); drv(5'h00, 1'b1, 1'b1);
        cyc(); drv(5'h01, 1'b1, 1'b0);

        // credit exhaustion
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("ex_pop", bus.vc_pop, 5'h01);
            chk("ex_credits", bus.credits_avail, 4 - k);
            cyc();
        end
        @(negedge clk);
        chk("ex_stall_pop", bus.vc_pop, 0);
        chk("ex_stall_credits", bus.credits_avail, 0);
        cyc(); bus.credit_in = 1'b1;
        @(negedge clk);
        chk("ex_ret_pop", bus.vc_pop, 0);
        cyc(); bus.credit_in = 1'b0;
        @(negedge clk);
        chk("ex_regrant_pop", bus.vc_pop, 5'h01);
        chk("ex_regrant_credits", bus.credits_avail, 1);
        cyc();
        @(negedge clk);
        chk("ex_after_pop", bus.vc_pop, 0);

        // backpressure
        cyc(); drv(5'h00, 1'b1, 1'b1);
        repeat (2) cyc();
        drv(5'h04, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_pop1", bus.vc_pop, 5'h04);
        cyc();
        @(negedge clk);
        chk("bp_hold_pop", bus.vc_pop, 0);
        chk("bp_valid", bus.out_valid, 1);
        chk("bp_pkt", bus.out_packet, 32'hA000_0002);
        cyc();
        @(negedge clk);
        chk("bp_pkt_stable", bus.out_packet, 32'hA000_0002);
        cyc(); bus.vc_data[2*DW +: DW] = 32'hB000_0002; bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop2", bus.vc_pop, 5'h04);
        cyc();
        @(negedge clk);
        chk("bp_pkt2", bus.out_packet, 32'hB000_0002);
        chk("bp_credits", bus.credits_avail, 0);

        // masking and grant+credit in the same cycle
        cyc(); drv(5'h00, 1'b1, 1'b1);
        repeat (4) cyc();
        bus.port_mask = 5'h17; drv(5'h18, 1'b1, 1'b0);
        @(negedge clk);
        chk("mask_pop", bus.vc_pop, 5'h10);
        cyc(); bus.credit_in = 1'b1;
        @(negedge clk);
        chk("mask_pop2", bus.vc_pop, 5'h10);
        chk("mask_credits", bus.credits_avail, 3);
        cyc(); bus.credit_in = 1'b0;
        @(negedge clk);
        chk("both_credits", bus.credits_avail, 3);
        chk("mask_last", bus.last_grant, 4);

        // credit overflow, then reset while a packet is held
        cyc(); drv(5'h00, 1'b1, 1'b1);
        repeat (2) cyc();
        @(negedge clk);
        chk("ovf_credits", bus.credits_avail, 4);
        chk("ovf_err_clear", bus.credit_err, 0);
        cyc(); bus.credit_in = 1'b0;
        @(negedge clk);
        chk("ovf_err", bus.credit_err, 1);
        chk("ovf_credits_sat", bus.credits_avail, 4);
        bus.port_mask = 5'h1F;
        cyc(); drv(5'h01, 1'b0, 1'b0);
        cyc();
        @(negedge clk);
        chk("mid_valid", bus.out_valid, 1);
        cyc(); rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_pop", bus.vc_pop, 0);
        cyc(); rst = 1'b0; drv(5'h03, 1'b1, 1'b0);
        @(negedge clk);
        chk("mid_valid_clr", bus.out_valid, 0);
        chk("mid_err_clr", bus.credit_err, 0);
        chk("mid_credits", bus.credits_avail, 4);
        chk("mid_ptr_pop", bus.vc_pop, 5'h01);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            cyc();
            rst           = ($urandom_range(0, 99) == 0);
            bus.vc_req    = N'($urandom);
            bus.port_mask = ($urandom_range(0, 3) != 0) ? 5'h1F : N'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.credit_in = ($urandom_range(0, 9) < 4);
            for (int i = 0; i < N; i++) bus.vc_data[i*DW +: DW] = $urandom;
        end
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
